// File: rtl/midi_pkg.sv
// Shared constants, state types and velocity scaling for the MIDI note source.
package midi_pkg;

    localparam logic [3:0] STAT_NOTE_OFF   = 4'h8;
    localparam logic [3:0] STAT_NOTE_ON    = 4'h9;
    localparam logic [3:0] STAT_PROG       = 4'hC;
    localparam logic [3:0] STAT_CHAN_PRESS = 4'hD;
    localparam logic [3:0] STAT_SYSTEM     = 4'hF;
    localparam logic [7:0] REALTIME_MIN    = 8'hF8;

    typedef enum logic [1:0] {
        RS_NONE     = 2'd0,
        RS_NOTE_OFF = 2'd1,
        RS_NOTE_ON  = 2'd2,
        RS_IGNORE   = 2'd3
    } run_status_t;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // 7-bit velocity stretched to full 8-bit range: 0x7F -> 0xFF, 0x00 -> 0x00
    function automatic logic [7:0] scale_velocity(input logic [6:0] vel);
        return {vel, vel[6]};
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver for the MIDI line: 2-FF synchroniser, mid-bit sampling,
// start-glitch rejection and stop-bit framing check.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 3200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       framing_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             prev_r;
    uart_state_t      state_r;
    uart_state_t      state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             fall_s;
    logic             half_hit_s;
    logic             full_hit_s;

    // Synchroniser registers reset low, so a line held low through reset never looks like a falling edge
    assign fall_s     = prev_r & ~sync2_r;
    assign half_hit_s = (cnt_r == HALF_LAST);
    assign full_hit_s = (cnt_r == FULL_LAST);

    // Receiver next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            UART_IDLE: begin
                if (fall_s) state_nx_s = UART_START;
                else        state_nx_s = UART_IDLE;
            end
            UART_START: begin
                if (half_hit_s) state_nx_s = sync2_r ? UART_IDLE : UART_DATA;
                else            state_nx_s = UART_START;
            end
            UART_DATA: begin
                if (full_hit_s && (bit_idx_r == 3'd7)) state_nx_s = UART_STOP;
                else                                   state_nx_s = UART_DATA;
            end
            UART_STOP: begin
                if (full_hit_s) state_nx_s = UART_IDLE;
                else            state_nx_s = UART_STOP;
            end
            default: state_nx_s = UART_IDLE;
        endcase
    end

    // Synchroniser, bit timer, shift register and registered result pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r       <= 1'b0;
            sync2_r       <= 1'b0;
            prev_r        <= 1'b0;
            state_r       <= UART_IDLE;
            cnt_r         <= '0;
            bit_idx_r     <= 3'd0;
            shift_r       <= 8'h00;
            dout          <= 8'h00;
            dout_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            sync1_r       <= rx;
            sync2_r       <= sync1_r;
            prev_r        <= sync2_r;
            state_r       <= state_nx_s;
            dout_valid    <= 1'b0;
            framing_error <= 1'b0;
            if ((state_nx_s != state_r) || full_hit_s) cnt_r <= '0;
            else                                       cnt_r <= cnt_r + CNT_W'(1);
            if (state_r == UART_START) bit_idx_r <= 3'd0;
            if ((state_r == UART_DATA) && full_hit_s) begin
                shift_r   <= {sync2_r, shift_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if ((state_r == UART_STOP) && full_hit_s) begin
                if (sync2_r) begin
                    dout       <= shift_r;
                    dout_valid <= 1'b1;
                end else begin
                    framing_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/midi_note_source.sv
// Monophonic last-note-priority MIDI Note On/Off decoder feeding an instrument voice;
// pitch and amplitude are held after note-off so the release phase keeps its pitch.
module midi_note_source
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 3200,
    parameter int CHANNEL      = 0,
    parameter int OMNI         = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    output logic [7:0] midi_data,
    output logic       midi_valid,
    output logic [7:0] amplitude,
    output logic       framing_error
);

    logic [7:0]  byte_s;
    logic        byte_valid_s;
    run_status_t rs_r;
    run_status_t rs_nx_s;
    logic        dcnt_r;
    logic        dcnt_nx_s;
    logic        need_two_r;
    logic        need_two_nx_s;
    logic [6:0]  note_r;
    logic [6:0]  note_nx_s;
    logic [6:0]  data_nx_s;
    logic        valid_nx_s;
    logic [7:0]  amp_nx_s;
    logic        chan_ok_s;
    logic        release_s;

    midi_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (midi_in),
        .dout          (byte_s),
        .dout_valid    (byte_valid_s),
        .framing_error (framing_error)
    );

    // Message parser: running status, data-byte count and note execution
    always_comb begin
        rs_nx_s       = rs_r;
        dcnt_nx_s     = dcnt_r;
        need_two_nx_s = need_two_r;
        note_nx_s     = note_r;
        data_nx_s     = midi_data[6:0];
        valid_nx_s    = midi_valid;
        amp_nx_s      = amplitude;
        chan_ok_s     = (OMNI != 0) || (byte_s[3:0] == 4'(CHANNEL));
        release_s     = midi_valid && (note_r == midi_data[6:0]);
        if (!byte_valid_s || (byte_s >= REALTIME_MIN)) begin
            rs_nx_s = rs_r;
        end else if (byte_s[7:4] == STAT_SYSTEM) begin
            rs_nx_s   = RS_NONE;
            dcnt_nx_s = 1'b0;
        end else if (byte_s[7]) begin
            dcnt_nx_s = 1'b0;
            if (chan_ok_s && (byte_s[7:4] == STAT_NOTE_OFF)) begin
                rs_nx_s       = RS_NOTE_OFF;
                need_two_nx_s = 1'b1;
            end else if (chan_ok_s && (byte_s[7:4] == STAT_NOTE_ON)) begin
                rs_nx_s       = RS_NOTE_ON;
                need_two_nx_s = 1'b1;
            end else begin
                rs_nx_s       = RS_IGNORE;
                need_two_nx_s = (byte_s[7:4] != STAT_PROG) && (byte_s[7:4] != STAT_CHAN_PRESS);
            end
        end else if (rs_r == RS_NONE) begin
            dcnt_nx_s = 1'b0;
        end else if (need_two_r && !dcnt_r) begin
            note_nx_s = byte_s[6:0];
            dcnt_nx_s = 1'b1;
        end else begin
            // Final data byte: execute, keep running status for the next message
            dcnt_nx_s = 1'b0;
            case (rs_r)
                RS_NOTE_ON: begin
                    if (byte_s[6:0] != 7'd0) begin
                        data_nx_s  = note_r;
                        amp_nx_s   = scale_velocity(byte_s[6:0]);
                        valid_nx_s = 1'b1;
                    end else if (release_s) begin
                        valid_nx_s = 1'b0;
                    end else begin
                        valid_nx_s = midi_valid;
                    end
                end
                RS_NOTE_OFF: begin
                    if (release_s) valid_nx_s = 1'b0;
                    else           valid_nx_s = midi_valid;
                end
                default: valid_nx_s = midi_valid;
            endcase
        end
    end

    // Parser state and registered voice outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs_r       <= RS_NONE;
            dcnt_r     <= 1'b0;
            need_two_r <= 1'b1;
            note_r     <= 7'd0;
            midi_data  <= 8'h00;
            midi_valid <= 1'b0;
            amplitude  <= 8'h00;
        end else begin
            rs_r       <= rs_nx_s;
            dcnt_r     <= dcnt_nx_s;
            need_two_r <= need_two_nx_s;
            note_r     <= note_nx_s;
            midi_data  <= {1'b0, data_nx_s};
            midi_valid <= valid_nx_s;
            amplitude  <= amp_nx_s;
        end
    end

endmodule

// File: tb/tb_midi_note_source.sv
// Directed plus randomized serial stimulus for midi_note_source, checked against a
// message-level reference model (status byte + pending data-byte queue).
module tb_midi_note_source;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       midi_in;
    logic [7:0] midi_data;
    logic       midi_valid;
    logic [7:0] amplitude;
    logic       framing_error;

    int checks = 0;
    int errors = 0;
    int bv_cnt = 0;
    int fe_tot = 0;

    logic [7:0] m_data;
    logic [7:0] m_amp;
    logic       m_valid;
    logic       st_ok;
    logic [7:0] st_byte;
    logic [7:0] pend[$];

    midi_note_source #(
        .CLKS_PER_BIT (CPB),
        .CHANNEL      (0),
        .OMNI         (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .midi_in       (midi_in),
        .midi_data     (midi_data),
        .midi_valid    (midi_valid),
        .amplitude     (amplitude),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    // Running tallies of received bytes and framing pulses
    always @(posedge clk) begin
        if (dut.byte_valid_s) bv_cnt++;
        if (framing_error) fe_tot++;
    end

    function automatic void model_reset();
        m_data  = 8'h00;
        m_amp   = 8'h00;
        m_valid = 1'b0;
        st_ok   = 1'b0;
        st_byte = 8'h00;
        pend.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int need;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            st_ok = 1'b0;
            pend.delete();
            return;
        end
        if (b >= 8'h80) begin
            st_ok   = 1'b1;
            st_byte = b;
            pend.delete();
            return;
        end
        if (!st_ok) return;
        pend.push_back(b);
        need = ((st_byte[7:4] == 4'hC) || (st_byte[7:4] == 4'hD)) ? 1 : 2;
        if (pend.size() < need) return;
        if (need == 2 && st_byte[3:0] == 4'h0) begin
            if (st_byte[7:4] == 4'h9 && pend[1] != 8'h00) begin
                m_data  = pend[0];
                m_amp   = 8'(int'(pend[1]) * 2 + int'(pend[1]) / 64);
                m_valid = 1'b1;
            end else if ((st_byte[7:4] == 4'h8 || st_byte[7:4] == 4'h9) && m_valid && pend[0] == m_data) begin
                m_valid = 1'b0;
            end
        end
        pend.delete();
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, " midi_data"}, midi_data, m_data);
        chk({tag, " midi_valid"}, {7'd0, midi_valid}, {7'd0, m_valid});
        chk({tag, " amplitude"}, amplitude, m_amp);
    endtask

    // One full frame; outputs must be unchanged in the byte_valid cycle and updated the next cycle
    task automatic send_byte(input logic [7:0] b, input logic good_stop);
        int   seen    = 0;
        int   fe      = 0;
        logic pending = 1'b0;
        midi_in = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_in = b[i];
            repeat (CPB) @(posedge clk);
        end
        midi_in = good_stop;
        for (int i = 0; i < CPB + 6; i++) begin
            if (i == CPB) midi_in = 1'b1;
            @(posedge clk);
            #1;
            if (pending) begin
                chk_outs("post");
                pending = 1'b0;
            end
            if (framing_error) fe++;
            if (dut.byte_valid_s) begin
                seen++;
                chk_outs("pre");
                model_byte(b);
                pending = 1'b1;
            end
        end
        chk("byte_valid count", 8'(seen), good_stop ? 8'd1 : 8'd0);
        chk("framing pulse cycles", 8'(fe), good_stop ? 8'd0 : 8'd1);
    endtask

    initial begin
        logic [7:0] b3c;
        logic [7:0] rb;
        int         r;
        int         bv_mark;
        int         fe_mark;

        rst_n   = 1'b0;
        midi_in = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        chk_outs("reset");
        chk("reset framing_error", {7'd0, framing_error}, 8'd0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;

        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        chk("t1 data", midi_data, 8'h3C);
        chk("t1 amp", amplitude, 8'hC9);
        chk("t1 valid", {7'd0, midi_valid}, 8'd1);

        send_byte(8'h40, 1'b1);
        send_byte(8'h7F, 1'b1);
        chk("t2 data", midi_data, 8'h40);
        chk("t2 amp", amplitude, 8'hFF);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("t2 other-off valid", {7'd0, midi_valid}, 8'd1);
        send_byte(8'h80, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h10, 1'b1);
        chk("t2 off valid", {7'd0, midi_valid}, 8'd0);
        chk("t2 off data held", midi_data, 8'h40);
        chk("t2 off amp held", amplitude, 8'hFF);

        send_byte(8'h90, 1'b1);
        send_byte(8'hF8, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'h50, 1'b1);
        chk("t3 data", midi_data, 8'h3C);
        chk("t3 amp", amplitude, 8'hA1);
        chk("t3 valid", {7'd0, midi_valid}, 8'd1);

        send_byte(8'h91, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        send_byte(8'hB0, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h64, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        chk("t4 filtered amp", amplitude, 8'hA1);
        send_byte(8'hC0, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h90, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h40, 1'b1);
        chk("t4 data", midi_data, 8'h30);
        chk("t4 amp", amplitude, 8'h81);

        send_byte(8'hF0, 1'b1);
        send_byte(8'h90, 1'b0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        chk("t5 data unchanged", midi_data, 8'h30);

        send_byte(8'h90, 1'b1);
        b3c     = 8'h3C;
        midi_in = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            midi_in = b3c[i];
            repeat (CPB) @(posedge clk);
        end
        midi_in = b3c[4];
        repeat (CPB / 2) @(posedge clk);
        rst_n   = 1'b0;
        midi_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_reset();
        chk_outs("mid-reset");
        rst_n   = 1'b1;
        bv_mark = bv_cnt;
        fe_mark = fe_tot;
        repeat (3 * CPB) @(posedge clk);
        #1;
        chk("low line no byte", 8'(bv_cnt - bv_mark), 8'd0);
        chk("low line no framing", 8'(fe_tot - fe_mark), 8'd0);
        midi_in = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        send_byte(8'h90, 1'b1);
        send_byte(8'h45, 1'b1);
        send_byte(8'h01, 1'b1);
        chk("t6 data", midi_data, 8'h45);
        chk("t6 amp", amplitude, 8'h02);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 11);
            case (r)
                0:       rb = 8'h90;
                1:       rb = 8'h80;
                2:       rb = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 15))};
                3:       rb = 8'(8'hF8 + $urandom_range(0, 7));
                4:       rb = 8'(8'hF0 + $urandom_range(0, 7));
                5, 6:    rb = 8'(8'h3C + $urandom_range(0, 2));
                7:       rb = 8'h00;
                default: rb = 8'($urandom_range(0, 127));
            endcase
            send_byte(rb, ($urandom_range(0, 24) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
